// File: rtl/ttt_pkg.sv
// ttt_pkg -- shared definitions for the tic-tac-toe board logic.
//   CELL_*    : 2-bit cell encoding (11 is never written)
//   NUM_CELLS : number of board cells
//   state_t   : move-writer FSM state encoding
package ttt_pkg;

  localparam int NUM_CELLS = 9;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  typedef enum logic [1:0] {
    P_MOVE = 2'd0,
    C_MOVE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/button_edge.sv
// button_edge -- rising-edge detector for a debounced button level.
//   clock : system clock
//   reset : asynchronous, active-high; clears the delayed copy
//   level : debounced button level
//   rise  : high while level is 1 and its registered copy is still 0
module button_edge (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_d;

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) level_d <= 1'b0;
    else       level_d <= level;
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/board_move_writer.sv
// board_move_writer -- owns the nine tic-tac-toe cells and writes moves.
//   Parameter PLAYER_FIRST  : side to move after reset (1 = player, 0 = computer)
//   clock, reset            : system clock, asynchronous active-high reset
//   play, pc                : debounced move buttons; a rising edge requests a move
//   player_pos, computer_pos: target cell index (0-8) for each side
//   winner                  : three-in-a-row flag from the winner detector
//   pos0 .. pos8            : registered cell contents (00 empty, 01 X, 10 O)
//   turn                    : 1 = player to move, 0 = computer to move
//   illegal_move            : one-cycle pulse when a move is rejected
//   no_space                : all nine cells occupied
//   game_over               : FSM is in DONE
//   move_count              : accepted writes, saturating at 9 (only with
//                             TTT_MOVE_COUNT_EN defined)
module board_move_writer
  import ttt_pkg::*;
#(
  parameter bit PLAYER_FIRST = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       play,
  input  logic       pc,
  input  logic [3:0] player_pos,
  input  logic [3:0] computer_pos,
  input  logic       winner,
  output logic [1:0] pos0,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic       turn,
  output logic       illegal_move,
  output logic       no_space,
`ifdef TTT_MOVE_COUNT_EN
  output logic [3:0] move_count,
`endif
  output logic       game_over
);

  logic [1:0] cells [NUM_CELLS];
  state_t     state, state_nxt;
  logic       play_req, pc_req;
  logic       armed;
  logic       side_req;
  logic [3:0] side_pos;
  logic [1:0] side_val;
  logic       target_free, fills_board;
  logic       wr_en, illegal_nxt;

  button_edge u_play_edge (.clock(clock), .reset(reset), .level(play), .rise(play_req));
  button_edge u_pc_edge   (.clock(clock), .reset(reset), .level(pc),   .rise(pc_req));

  // Only the side on turn is evaluated; the other button is ignored.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    side_req    = (state == P_MOVE) ? play_req   : pc_req;
    side_pos    = (state == P_MOVE) ? player_pos : computer_pos;
    side_val    = (state == P_MOVE) ? CELL_X     : CELL_O;
    target_free = 1'b0;
    fills_board = 1'b1;
    // An index above 8 matches no cell, so target_free stays 0 and the
    // request is rejected as illegal.
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (side_pos == 4'(i))              target_free = (cells[i] == CELL_EMPTY);
      else if (cells[i] == CELL_EMPTY)    fills_board = 1'b0;
    end

    state_nxt   = state;
    wr_en       = 1'b0;
    illegal_nxt = 1'b0;
    if (state != DONE) begin
      if (winner) begin
        state_nxt = DONE;
      end else if (side_req && armed) begin
        if (target_free) begin
          wr_en     = 1'b1;
          state_nxt = fills_board ? DONE : ((state == P_MOVE) ? C_MOVE : P_MOVE);
        end else begin
          illegal_nxt = 1'b1;
        end
      end
    end
  end

  // armed stays low for the first edge after reset release: a button held
  // through reset looks like a rising edge there (its delayed copy was
  // cleared), and that must not count as a fresh request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= PLAYER_FIRST ? P_MOVE : C_MOVE;
      illegal_move <= 1'b0;
      armed        <= 1'b0;
      // NOTE: the cell array is reset explicitly because the board must read
      // empty immediately on reset; it is nine flops, not a RAM.
      for (int i = 0; i < NUM_CELLS; i++) cells[i] <= CELL_EMPTY;
    end else begin
      state        <= state_nxt;
      illegal_move <= illegal_nxt;
      armed        <= 1'b1;
      if (wr_en) begin
        for (int i = 0; i < NUM_CELLS; i++) begin
          if (side_pos == 4'(i)) cells[i] <= side_val;
        end
      end
    end
  end

`ifdef TTT_MOVE_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                   move_count <= 4'd0;
    else if (wr_en && move_count != 4'(NUM_CELLS)) move_count <= move_count + 4'd1;
  end

  assign no_space = (move_count == 4'(NUM_CELLS));
`else
  logic [NUM_CELLS-1:0] occupied;

  always_comb begin
    occupied = '0;
    for (int i = 0; i < NUM_CELLS; i++) occupied[i] = (cells[i] != CELL_EMPTY);
  end

  assign no_space = &occupied;
`endif

  assign turn      = (state == P_MOVE);
  assign game_over = (state == DONE);

  assign pos0 = cells[0];
  assign pos1 = cells[1];
  assign pos2 = cells[2];
  assign pos3 = cells[3];
  assign pos4 = cells[4];
  assign pos5 = cells[5];
  assign pos6 = cells[6];
  assign pos7 = cells[7];
  assign pos8 = cells[8];

endmodule

// File: doc/board_move_writer.md
# board_move_writer

Sequential board owner for the tic-tac-toe game: holds the nine 2-bit cell registers and writes player and computer moves into them. Its board outputs feed the combinational winner detectors, and it stops accepting moves once their winner signal asserts. Cell encoding: 00 empty, 01 player (X), 10 computer (O). 11 is never written.

## Interface
- PLAYER_FIRST, default 1: side to move after reset (1 = player, 0 = computer).
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears board and FSM.
- play  in  1  player move button, debounced level; a rising edge requests a move.
- pc  in  1  computer move button, debounced level; a rising edge requests a move.
- player_pos  in  4  cell index 0–8 for the player move.
- computer_pos  in  4  cell index 0–8 for the computer move.
- winner  in  1  from the winner detector; high = three in a row on the current board.
- pos0 … pos8  out  2 each  registered cell contents.
- turn  out  1  1 = player to move, 0 = computer to move; valid in the MOVE states only.
- illegal_move  out  1  one-cycle pulse when a move is rejected.
- no_space  out  1  high while all nine cells are non-zero.
- game_over  out  1  high in the DONE state.

## Operation
- Edge detect: play_d and pc_d are registered copies of play and pc. A request is `play & ~play_d` (likewise for pc).
- FSM states:
  - P_MOVE: waiting for a player move.
  - C_MOVE: waiting for a computer move.
  - DONE: game finished.
- Reset state: P_MOVE if PLAYER_FIRST=1, else C_MOVE.
- Priority in P_MOVE and C_MOVE, highest first:
  1. winner=1 → DONE. Any request in the same cycle is discarded and no cell is written.
  2. A request from the side whose turn it is, with index ≤ 8 and the target cell 00:
     - the cell is written (01 for player, 10 for computer);
     - the FSM goes to the other side's MOVE state;
     - if this write fills the ninth cell, the FSM goes to DONE instead.
  3. A request from the side to move with index > 8 or an occupied target: illegal_move pulses for 1 cycle, nothing is written, the state is unchanged.
- Requests from the side not on turn are ignored silently: no write, no illegal pulse.
- Simultaneous play and pc edges: only the side on turn is evaluated.
- DONE: all requests are ignored and illegal_move stays 0. Only reset leaves DONE.
- Writes only transition cells from 00 to 01 or 10. A cell never changes again until reset.

## Timing
- Reset values (asynchronous):
  - pos0–pos8 = 00, play_d = pc_d = 0;
  - turn = PLAYER_FIRST, illegal_move = 0, no_space = 0, game_over = 0.
- Move latency: the write is visible on posN after the first rising edge at which the request edge is sampled (1 cycle). turn updates on the same edge.
- illegal_move is registered: high for exactly the one cycle after the edge that sampled the bad request.
- no_space and game_over are derived from registered state, so they are glitch-free.
- A button held high produces exactly one request. It must fall and rise again to request another move.
- Reset asserted mid-game clears everything immediately; the first request after reset release needs a fresh rising edge.

## Configuration
- Macro TTT_MOVE_COUNT_EN.
- Defined:
  - adds output move_count (4 bits, reset 0), incremented on every accepted write, saturating at 9;
  - no_space is computed as move_count == 9.
- Undefined:
  - no move_count port;
  - no_space is the AND of all nine cell non-zero checks.
- Externally visible no_space behaviour is identical in both builds.

## Structure
- Shared package ttt_pkg holds:
  - cell constants CELL_EMPTY = 2'b00, CELL_X = 2'b01, CELL_O = 2'b10;
  - NUM_CELLS = 9;
  - the FSM state encoding: P_MOVE, C_MOVE, DONE.
- Sub-module button_edge: one register plus a rising-edge pulse output. It is instantiated twice, for play and pc.

## Test plan
- Reset with PLAYER_FIRST=1, player_pos=4, play 0→1 → pos4=01, turn=0 one cycle later, illegal_move=0.
- After the above, computer_pos=4, pc 0→1 → illegal_move high for exactly 1 cycle, pos4 stays 01, turn stays 0. Then computer_pos=0, pc edge → pos0=10, turn=1.
- player_pos=9, play edge → illegal pulse, no write. Then a pc edge while turn=1 → ignored, no illegal pulse.
- Play X at 0,1,2 with O at 3,4 in between, then drive winner=1 in the same cycle as a computer request at 5 → game_over=1, pos5 stays 00, later requests ignored.
- Nine alternating legal moves with winner=0 throughout → no_space=1 and game_over=1 after the ninth write; with TTT_MOVE_COUNT_EN, move_count=9.
- Assert reset mid-game while play is held high → all cells 00 at once; after release, no move occurs until play falls and rises again.
